// File: rtl/ula_multiciclo.sv
//==============================================================================
// Module      : ula_multiciclo
// Description : ALU with program counter. Most opcodes complete in a single
//               cycle. Multiply (shift-add) and divide (restoring) are
//               iterative and take LARGURA cycles. Results go to the LO/HI
//               registers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ula_multiciclo #(
    parameter int LARGURA    = 16,
    parameter int LARGURA_PC = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic [3:0]            codop,
    input  logic [LARGURA-1:0]    operando1,
    input  logic [LARGURA-1:0]    operando2,
    input  logic [LARGURA-1:0]    imm,
    output logic [LARGURA-1:0]    dado,
    output logic [LARGURA-1:0]    res_low,
    output logic [LARGURA-1:0]    res_high,
    output logic [LARGURA_PC-1:0] pc,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  ini,
    output logic                  erro_div
);

    localparam int SHW = $clog2(LARGURA);

    localparam logic [1:0] c_OCIOSO = 2'd0;
    localparam logic [1:0] c_MULT   = 2'd1;
    localparam logic [1:0] c_DIV    = 2'd2;

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_SLT  = 4'b0010;
    localparam logic [3:0] c_OP_AND  = 4'b0011;
    localparam logic [3:0] c_OP_OR   = 4'b0100;
    localparam logic [3:0] c_OP_XOR  = 4'b0101;
    localparam logic [3:0] c_OP_SHL  = 4'b0110;
    localparam logic [3:0] c_OP_SHR  = 4'b0111;
    localparam logic [3:0] c_OP_MUL  = 4'b1000;
    localparam logic [3:0] c_OP_DIV  = 4'b1001;
    localparam logic [3:0] c_OP_MFLO = 4'b1010;
    localparam logic [3:0] c_OP_MFHI = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_BEQ  = 4'b1101;
    localparam logic [3:0] c_OP_HALT = 4'b1110;

    localparam logic [SHW-1:0] c_ULTIMO = SHW'(LARGURA - 1);

    logic [1:0]            r_estado;
    logic [SHW-1:0]        r_cont;
    logic [LARGURA-1:0]    r_hi;      // partial product high half / partial remainder
    logic [LARGURA-1:0]    r_lo;      // multiplier bits / dividend-then-quotient bits
    logic [LARGURA-1:0]    r_opnd;    // multiplicand / divisor captured at acceptance
    logic [LARGURA-1:0]    r_dado;
    logic [LARGURA-1:0]    r_res_low;
    logic [LARGURA-1:0]    r_res_high;
    logic [LARGURA_PC-1:0] r_pc;
    logic                  r_pronto;
    logic                  r_ini;
    logic                  r_erro;

    logic                  w_aceita;
    logic [SHW-1:0]        w_shamt;
    logic [LARGURA-1:0]    w_alu;
    logic [LARGURA_PC-1:0] w_pc_inc;
    logic signed [LARGURA_PC-1:0] w_imm_se;
    logic [LARGURA_PC-1:0] w_pc_prox;
    logic [LARGURA:0]      w_soma;
    logic [LARGURA-1:0]    w_mult_hi;
    logic [LARGURA-1:0]    w_mult_lo;
    logic [LARGURA:0]      w_desl;
    logic [LARGURA:0]      w_dif;
    logic                  w_cabe;
    logic [LARGURA-1:0]    w_div_hi;
    logic [LARGURA-1:0]    w_div_lo;

    assign w_aceita = inicio && (r_estado == c_OCIOSO);
    assign w_shamt  = operando2[SHW-1:0];
    assign w_pc_inc = r_pc + LARGURA_PC'(1);
    assign w_imm_se = $signed(imm);

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the {hi,lo} pair right by one.
    assign w_soma    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(LARGURA+1){1'b0}});
    assign w_mult_hi = w_soma[LARGURA:1];
    assign w_mult_lo = {w_soma[0], r_lo[LARGURA-1:1]};

    // One restoring-division step: shift the next dividend bit into the
    // remainder and keep the difference only when no borrow occurs.
    assign w_desl   = {r_hi, r_lo[LARGURA-1]};
    assign w_dif    = w_desl - {1'b0, r_opnd};
    assign w_cabe   = ~w_dif[LARGURA];
    assign w_div_hi = w_cabe ? w_dif[LARGURA-1:0] : w_desl[LARGURA-1:0];
    assign w_div_lo = {r_lo[LARGURA-2:0], w_cabe};

    // Single-cycle datapath result; jump/branch/halt/nop keep dado as is
    always_comb begin
        w_alu = r_dado;
        case (codop)
            c_OP_ADD:  w_alu = operando1 + operando2;
            c_OP_SUB:  w_alu = operando1 - operando2;
            c_OP_SLT:  w_alu = (operando1 < operando2) ? LARGURA'(1) : '0;
            c_OP_AND:  w_alu = operando1 & operando2;
            c_OP_OR:   w_alu = operando1 | operando2;
            c_OP_XOR:  w_alu = operando1 ^ operando2;
            c_OP_SHL:  w_alu = operando1 << w_shamt;
            c_OP_SHR:  w_alu = operando1 >> w_shamt;
            c_OP_MFLO: w_alu = r_res_low;
            c_OP_MFHI: w_alu = r_res_high;
            default:   w_alu = r_dado;
        endcase
    end

    // Next program counter for an accepted instruction
    always_comb begin
        w_pc_prox = w_pc_inc;
        if (codop == c_OP_JMP) begin
            w_pc_prox = LARGURA_PC'(imm);
        end else if ((codop == c_OP_BEQ) && (operando1 == operando2)) begin
            w_pc_prox = w_pc_inc + w_imm_se;
        end
    end

    // Control FSM, iterative multiply/divide and architectural registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= c_OCIOSO;
            r_cont     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_dado     <= '0;
            r_res_low  <= '0;
            r_res_high <= '0;
            r_pc       <= '0;
            r_pronto   <= 1'b0;
            r_ini      <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            r_ini    <= 1'b0;
            case (r_estado)
                c_OCIOSO: begin
                    if (w_aceita) begin
                        r_pc     <= w_pc_prox;
                        r_erro   <= 1'b0;
                        r_pronto <= 1'b1;
                        r_ini    <= (codop == c_OP_HALT);
                        r_cont   <= '0;
                        if (codop == c_OP_MUL) begin
                            r_pronto <= 1'b0;
                            r_estado <= c_MULT;
                            r_hi     <= '0;
                            r_lo     <= operando2;
                            r_opnd   <= operando1;
                        end else if (codop == c_OP_DIV) begin
                            if (operando2 == '0) begin
                                // Divide by zero finishes immediately with a flag
                                r_res_low  <= '1;
                                r_res_high <= operando1;
                                r_dado     <= '1;
                                r_erro     <= 1'b1;
                            end else begin
                                r_pronto <= 1'b0;
                                r_estado <= c_DIV;
                                r_hi     <= '0;
                                r_lo     <= operando1;
                                r_opnd   <= operando2;
                            end
                        end else begin
                            r_dado <= w_alu;
                        end
                    end
                end
                c_MULT, c_DIV: begin
                    r_cont <= r_cont + SHW'(1);
                    r_hi   <= (r_estado == c_MULT) ? w_mult_hi : w_div_hi;
                    r_lo   <= (r_estado == c_MULT) ? w_mult_lo : w_div_lo;
                    if (r_cont == c_ULTIMO) begin
                        r_res_high <= (r_estado == c_MULT) ? w_mult_hi : w_div_hi;
                        r_res_low  <= (r_estado == c_MULT) ? w_mult_lo : w_div_lo;
                        r_pronto   <= 1'b1;
                        r_estado   <= c_OCIOSO;
                    end
                end
                default: r_estado <= c_OCIOSO;
            endcase
        end
    end

    assign dado     = r_dado;
    assign res_low  = r_res_low;
    assign res_high = r_res_high;
    assign pc       = r_pc;
    assign ocupado  = (r_estado != c_OCIOSO);
    assign pronto   = r_pronto;
    assign ini      = r_ini;
    assign erro_div = r_erro;

endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
//==============================================================================
// Module      : tb_ula_multiciclo
// Description : Self-checking bench for ula_multiciclo (LARGURA=16, PC=32).
//               A reference model pushes the expected results to a queue
//               when each instruction is issued. Entries are popped and
//               compared when the DUT raises pronto.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ula_multiciclo;

    localparam int W  = 16;
    localparam int WP = 32;

    typedef struct {
        logic [W-1:0]  dado;
        logic          dado_ok;
        logic [WP-1:0] pc;
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
        logic          err;
        logic          ini;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inicio = 1'b0;
    logic [3:0]    codop = 4'b1111;
    logic [W-1:0]  operando1 = '0;
    logic [W-1:0]  operando2 = '0;
    logic [W-1:0]  imm = '0;
    logic [W-1:0]  dado, res_low, res_high;
    logic [WP-1:0] pc;
    logic          ocupado, pronto, ini, erro_div;

    exp_t q[$];
    int   n_chk = 0;
    int   n_ok  = 0;

    // Reference model state
    logic [W-1:0]  m_dado = '0;
    logic          m_dado_ok = 1'b1;
    logic [WP-1:0] m_pc = '0;
    logic [W-1:0]  m_lo = '0;
    logic [W-1:0]  m_hi = '0;
    logic          m_err = 1'b0;

    ula_multiciclo #(.LARGURA(W), .LARGURA_PC(WP)) dut (
        .clock     (clk),
        .reset     (reset),
        .inicio    (inicio),
        .codop     (codop),
        .operando1 (operando1),
        .operando2 (operando2),
        .imm       (imm),
        .dado      (dado),
        .res_low   (res_low),
        .res_high  (res_high),
        .pc        (pc),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .ini       (ini),
        .erro_div  (erro_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Update the model, push the expectation, drive one instruction and
    // compare against the popped entry when pronto shows up.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] im, input bit hold_xor);
        exp_t        e;
        exp_t        g;
        logic [31:0] p;
        int          n;
        int          nbusy;
        m_err = 1'b0;
        m_pc  = m_pc + 32'd1;
        e.lat = 0;
        e.ini = 1'b0;
        case (op)
            4'b0000: begin m_dado = a + b;                m_dado_ok = 1'b1; end
            4'b0001: begin m_dado = a - b;                m_dado_ok = 1'b1; end
            4'b0010: begin m_dado = (a < b) ? 16'd1 : 16'd0; m_dado_ok = 1'b1; end
            4'b0011: begin m_dado = a & b;                m_dado_ok = 1'b1; end
            4'b0100: begin m_dado = a | b;                m_dado_ok = 1'b1; end
            4'b0101: begin m_dado = a ^ b;                m_dado_ok = 1'b1; end
            4'b0110: begin m_dado = a << b[3:0];          m_dado_ok = 1'b1; end
            4'b0111: begin m_dado = a >> b[3:0];          m_dado_ok = 1'b1; end
            4'b1000: begin
                p = 32'(a) * 32'(b);
                m_hi = p[31:16]; m_lo = p[15:0]; e.lat = W;
            end
            4'b1001: begin
                if (b == 16'd0) begin
                    m_lo = 16'hFFFF; m_hi = a; m_err = 1'b1; m_dado_ok = 1'b0;
                end else begin
                    m_lo = a / b; m_hi = a % b; e.lat = W;
                end
            end
            4'b1010: begin m_dado = m_lo; m_dado_ok = 1'b1; end
            4'b1011: begin m_dado = m_hi; m_dado_ok = 1'b1; end
            4'b1100: m_pc = {16'h0000, im};
            4'b1101: if (a == b) m_pc = m_pc + {{16{im[15]}}, im};
            4'b1110: e.ini = 1'b1;
            default: ;
        endcase
        e.dado = m_dado; e.dado_ok = m_dado_ok; e.pc = m_pc;
        e.lo = m_lo; e.hi = m_hi; e.err = m_err;
        q.push_back(e);

        @(negedge clk);
        inicio = 1'b1; codop = op; operando1 = a; operando2 = b; imm = im;
        @(negedge clk);
        // Operands change after acceptance; only the captured ones matter
        operando1 = $urandom; operando2 = $urandom; imm = $urandom;
        if (hold_xor) codop = 4'b0101;
        else inicio = 1'b0;
        n = 0; nbusy = 0;
        while (!pronto && n < 40) begin
            if (ocupado) nbusy++;
            @(negedge clk);
            n++;
        end
        inicio = 1'b0;
        if (!pronto) chk("pronto_timeout", 64'(pronto), 64'd1);
        g = q.pop_front();
        chk("latency", 64'(n), 64'(g.lat));
        chk("busy_cycles", 64'(nbusy), 64'(g.lat));
        if (g.dado_ok) chk("dado", 64'(dado), 64'(g.dado));
        chk("pc", 64'(pc), 64'(g.pc));
        chk("res_low", 64'(res_low), 64'(g.lo));
        chk("res_high", 64'(res_high), 64'(g.hi));
        chk("erro_div", 64'(erro_div), 64'(g.err));
        chk("ini", 64'(ini), 64'(g.ini));
        chk("ocupado_done", 64'(ocupado), 64'd0);
        @(negedge clk);
        chk("pronto_pulse", 64'(pronto), 64'd0);
        chk("ini_pulse", 64'(ini), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dado"}, 64'(dado), 64'd0);
        chk({tag, "_lo"}, 64'(res_low), 64'd0);
        chk({tag, "_hi"}, 64'(res_high), 64'd0);
        chk({tag, "_pc"}, 64'(pc), 64'd0);
        chk({tag, "_ocupado"}, 64'(ocupado), 64'd0);
        chk({tag, "_pronto"}, 64'(pronto), 64'd0);
        chk({tag, "_ini"}, 64'(ini), 64'd0);
        chk({tag, "_erro"}, 64'(erro_div), 64'd0);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb, ri;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Wrap-around add and the other single-cycle operations
        issue(4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
        issue(4'b0001, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        issue(4'b0010, 16'h0003, 16'h0005, 16'h0000, 1'b0);
        issue(4'b0010, 16'h8000, 16'h0003, 16'h0000, 1'b0);
        issue(4'b0011, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0);
        issue(4'b0100, 16'hF0F0, 16'h0F01, 16'h0000, 1'b0);
        issue(4'b0101, 16'hAAAA, 16'hFFFF, 16'h0000, 1'b0);
        issue(4'b0110, 16'h0001, 16'h0013, 16'h0000, 1'b0);
        issue(4'b0111, 16'h8000, 16'h0004, 16'h0000, 1'b0);

        // Maximum multiply, then read LO/HI
        issue(4'b1000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
        issue(4'b1010, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        issue(4'b1011, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // Divide with an xor held on inicio for the whole busy period
        issue(4'b1001, 16'd100, 16'd7, 16'h0000, 1'b1);
        // Divide by zero and the flag clearing on the next instruction
        issue(4'b1001, 16'd100, 16'd0, 16'h0000, 1'b0);
        issue(4'b0000, 16'd1, 16'd2, 16'h0000, 1'b0);

        // Jump and branches from pc=10
        issue(4'b1100, 16'h0000, 16'h0000, 16'd10, 1'b0);
        issue(4'b1101, 16'd5, 16'd5, 16'hFFFE, 1'b0);
        issue(4'b1100, 16'h0000, 16'h0000, 16'd10, 1'b0);
        issue(4'b1101, 16'd5, 16'd6, 16'hFFFE, 1'b0);
        issue(4'b1100, 16'h0000, 16'h0000, 16'h0123, 1'b0);
        issue(4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        issue(4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b0);

        // Random instruction mix
        for (int k = 0; k < 30; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            ri  = 16'($urandom);
            issue(rop, ra, rb, ri, 1'b0);
        end

        // Reset during the fifth busy cycle of a multiply
        @(negedge clk);
        inicio = 1'b1; codop = 4'b1000; operando1 = 16'hFFFF; operando2 = 16'hFFFF;
        @(negedge clk);
        inicio = 1'b0;
        repeat (4) @(negedge clk);
        chk("mult_busy_before_reset", 64'(ocupado), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        reset = 1'b0;
        m_dado = '0; m_dado_ok = 1'b1; m_pc = '0; m_lo = '0; m_hi = '0; m_err = 1'b0;
        issue(4'b0000, 16'h1111, 16'h2222, 16'h0000, 1'b0);
        repeat (20) @(negedge clk);
        chk("abort_lo_kept", 64'(res_low), 64'd0);
        chk("abort_hi_kept", 64'(res_high), 64'd0);
        chk("abort_no_pronto", 64'(pronto), 64'd0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
